alu_reservation_station: RTL
============================

// Module: alu_reservation_station
// PURPOSE
//  Consumes the registered decode-stage bundle and buffers ALU-class instructions until both operands are
//  valid. Captures operands broadcast on the common data bus (CDB). Issues the oldest ready entry to the
//  ALU with a valid/ready handshake. Raises rsFull back to decode as a dispatch stall.
// PARAMETERS
//  WIDTH      31   MSB index of data/PC words (32-bit)
//  ROB        2    MSB index of ROB tags (8 entries)
//  A_WIDTH    3    MSB index of ALUControl
//  RS         1    MSB index of RSstation
//  STATION_ID 0    RSstation code this instance accepts
//  ENTRIES    4    buffer depth (2..8)
// PORTS
//  clk            in   1        rising-edge clock
//  reset_n        in   1        asynchronous, active-low reset
//  flush          in   1        misprediction flush (robBus.controlFlow[0])
//  stationRequest in   1        decode bundle valid
//  RSstation      in   RS+1     target station; accepted only when == STATION_ID
//  ALUControl     in   A_WIDTH+1 ALU opcode
//  operand1/2     in   WIDTH+1  register/immediate operand values
//  busy1/busy2    in   1        operand pending; value arrives via CDB under rob1/rob2
//  rob1/rob2      in   ROB+1    producer tags for pending operands
//  destROB        in   ROB+1    ROB entry allocated to this instruction
//  pc             in   WIDTH+1  instruction PC, carried through to the ALU
//  cdbValid       in   1        CDB broadcast valid
//  cdbROB         in   ROB+1    CDB tag
//  cdbResult      in   WIDTH+1  CDB value
//  rsFull         out  1        all entries valid; decode holds
//  issueValid     out  1        issue bundle valid
//  fuReady        in   1        ALU accepts the bundle this cycle
//  issueALUControl/issueOp1/issueOp2/issueROB/issuePC  out  bundle fields
// BEHAVIOUR
//  Reset (async, reset_n=0): all entry valid bits=0, age matrix=0, issueValid=0, rsFull=0.
//    Payload registers are not reset.
//  Dispatch: accepted when stationRequest && RSstation==STATION_ID && !rsFull && !flush. The bundle is
//    written at the next edge into the lowest-index free entry.
//  Dispatch bypass: if busyN && cdbValid && cdbROB==robN in the dispatch cycle, the entry stores cdbResult
//    with that operand ready.
//  Wakeup: each cycle, every valid entry with a pending operand whose tag equals cdbROB under cdbValid
//    captures cdbResult at the edge. Both operands of one entry can wake on the same broadcast.
//  Ready = valid && !pending1 && !pending2, evaluated from registered state only.
//    An operand woken in cycle t makes the entry selectable in t+1; it is issued at the end of t+1.
//  Select/issue: the issue register loads when !issueValid || fuReady. It takes the oldest ready entry
//    from the age matrix; that entry's valid bit clears at the same edge. If no entry is ready, issueValid=0.
//    The issue bundle holds stable while issueValid && !fuReady.
//  Latency: a dispatch with both operands ready is written at edge e and appears on issue outputs after
//    edge e+1 (minimum 2 cycles from decode output to ALU).
//  rsFull = &valid (combinational from registered valid bits). An entry freed by issue is reusable from
//    the next cycle; there is no same-cycle reuse.
//  Simultaneous dispatch+issue while full: dispatch is refused; issue proceeds.
//  Age matrix: on allocation of entry i, set row i for every currently valid entry (i is younger than all
//    of them) and clear column i. Oldest ready entry = ready entry with no older ready entry.
//  Flush (synchronous): at the next edge all valid bits=0 and issueValid=0; dispatch and CDB in the flush
//    cycle are ignored. rsFull deasserts the cycle after the flush edge.
//  Reset mid-operation: everything is discarded immediately; no partial issue.
//  ROB tags are compared as full ROB+1-bit values; no wrap handling is required in this block.
// STRUCTURE
//  Shared package (core_pkg): rs_entry_t {valid, aluc, op1, op2, pend1, pend2, tag1, tag2, dest, pc},
//    rs_issue_t, station code constants (STATION_ALU=0, ...).
//  One sub-module: rs_age_matrix (ENTRIES x ENTRIES bits; inputs alloc one-hot, free one-hot, ready
//    vector; outputs oldest-ready one-hot). The remainder is a single always_ff/always_comb pair.
// TESTING
//  1. Reset, then dispatch ADD with busy1=busy2=0, op1=5, op2=7, destROB=3, fuReady=1
//     -> issueValid=1 two cycles later with op1=5, op2=7, issueROB=3; rsFull never asserts.
//  2. Dispatch with busy1=1, rob1=2; three cycles later CDB (2, 0xDEAD)
//     -> issueOp1=0xDEAD, issued on the 2nd edge after the broadcast; no earlier issue.
//  3. Dispatch with busy2=1, rob2=6 while CDB drives tag 6 with value 9 the same cycle
//     -> bypass captures 9; issue follows dispatch by two edges.
//  4. Dispatch ENTRIES=4 pending instructions A,B,C,D with fuReady=0 -> rsFull=1 and a 5th dispatch is
//     ignored; wake all with one CDB tag -> issue order A,B,C,D when fuReady=1.
//  5. fuReady=0 with issueValid=1 for 3 cycles -> bundle bits unchanged; raise fuReady -> next oldest loads.
//  6. Full station with one ready entry; assert flush -> next cycle valid=0, issueValid=0, rsFull=0.
//     Async reset_n pulse mid-issue -> outputs 0 without a clock edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the out-of-order core's reservation stations:
// entry/issue payload layouts, station codes and the CDB tag-match helper.
package core_pkg;

    localparam int XLEN_MSB = 31;
    localparam int ROB_MSB  = 2;
    localparam int ALUC_MSB = 3;
    localparam int RS_MSB   = 1;

    localparam logic [RS_MSB:0] STATION_ALU    = 2'd0;
    localparam logic [RS_MSB:0] STATION_LSU    = 2'd1;
    localparam logic [RS_MSB:0] STATION_BRANCH = 2'd2;
    localparam logic [RS_MSB:0] STATION_MUL    = 2'd3;

    typedef struct packed {
        logic                valid;
        logic [ALUC_MSB:0]   aluc;
        logic [XLEN_MSB:0]   op1;
        logic [XLEN_MSB:0]   op2;
        logic                pend1;
        logic                pend2;
        logic [ROB_MSB:0]    tag1;
        logic [ROB_MSB:0]    tag2;
        logic [ROB_MSB:0]    dest;
        logic [XLEN_MSB:0]   pc;
    } rs_entry_t;

    typedef struct packed {
        logic [ALUC_MSB:0]   aluc;
        logic [XLEN_MSB:0]   op1;
        logic [XLEN_MSB:0]   op2;
        logic [ROB_MSB:0]    rob;
        logic [XLEN_MSB:0]   pc;
    } rs_issue_t;

    localparam rs_issue_t ISSUE_NONE = '{aluc: 4'd0, op1: 32'd0, op2: 32'd0, rob: 3'd0, pc: 32'd0};

    // A pending operand wakes when the broadcast tag matches its producer tag exactly.
    function automatic logic cdb_hit(input logic pend, input logic [ROB_MSB:0] tag,
                                     input logic cdb_valid, input logic [ROB_MSB:0] cdb_tag);
        return pend && cdb_valid && (tag == cdb_tag);
    endfunction

    function automatic rs_issue_t to_issue(input rs_entry_t e);
        return '{aluc: e.aluc, op1: e.op1, op2: e.op2, rob: e.dest, pc: e.pc};
    endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix for the reservation station: older_r[i][j]=1 means entry j is older
// than entry i. Produces a one-hot vector of the oldest ready entry.
module rs_age_matrix
    import core_pkg::*;
#(
    parameter int ENTRIES = 4
)(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [ENTRIES-1:0] alloc,
    input  logic [ENTRIES-1:0] free,
    input  logic [ENTRIES-1:0] valid,
    input  logic [ENTRIES-1:0] ready,
    output logic [ENTRIES-1:0] oldest
);

    logic [ENTRIES-1:0] older_r [ENTRIES];

    // Allocation makes the new entry younger than every surviving entry; alloc/free clear its column.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                older_r[i] <= {ENTRIES{1'b0}};
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                for (int j = 0; j < ENTRIES; j++) begin
                    if (alloc[i]) begin
                        older_r[i][j] <= valid[j] && !free[j];
                    end else if (alloc[j] || free[j]) begin
                        older_r[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    // Oldest ready = ready entry with no older ready entry.
    always_comb begin
        oldest = {ENTRIES{1'b0}};
        for (int i = 0; i < ENTRIES; i++) begin
            oldest[i] = ready[i] && ((older_r[i] & ready) == {ENTRIES{1'b0}});
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched ALU ops until both operands are
// captured from decode or the CDB, then issues the oldest ready one to the ALU.
module alu_reservation_station
    import core_pkg::*;
#(
    parameter int             WIDTH      = XLEN_MSB,
    parameter int             ROB        = ROB_MSB,
    parameter int             A_WIDTH    = ALUC_MSB,
    parameter int             RS         = RS_MSB,
    parameter logic [RS:0]    STATION_ID = STATION_ALU,
    parameter int             ENTRIES    = 4
)(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               stationRequest,
    input  logic [RS:0]        RSstation,
    input  logic [A_WIDTH:0]   ALUControl,
    input  logic [WIDTH:0]     operand1,
    input  logic [WIDTH:0]     operand2,
    input  logic               busy1,
    input  logic               busy2,
    input  logic [ROB:0]       rob1,
    input  logic [ROB:0]       rob2,
    input  logic [ROB:0]       destROB,
    input  logic [WIDTH:0]     pc,
    input  logic               cdbValid,
    input  logic [ROB:0]       cdbROB,
    input  logic [WIDTH:0]     cdbResult,
    output logic               rsFull,
    output logic               issueValid,
    input  logic               fuReady,
    output logic [A_WIDTH:0]   issueALUControl,
    output logic [WIDTH:0]     issueOp1,
    output logic [WIDTH:0]     issueOp2,
    output logic [ROB:0]       issueROB,
    output logic [WIDTH:0]     issuePC
);

    rs_entry_t          entry_r [ENTRIES];
    rs_issue_t          issue_r;
    logic               issue_valid_r;

    rs_entry_t          new_entry_s;
    rs_issue_t          issue_mux_s;
    logic [ENTRIES-1:0] valid_s, ready_s, free_vec_s, alloc_s, oldest_s, issue_sel_s;
    logic [ENTRIES-1:0] wake1_s, wake2_s;
    logic               dispatch_s, rs_full_s, issue_load_s, bypass1_s, bypass2_s;

    rs_age_matrix #(.ENTRIES(ENTRIES)) u_age (
        .clk     (clk),
        .reset_n (reset_n),
        .alloc   (alloc_s),
        .free    (issue_sel_s),
        .valid   (valid_s),
        .ready   (ready_s),
        .oldest  (oldest_s)
    );

    // Readiness, wakeup, allocation, selection and the dispatch bundle with CDB bypass.
    always_comb begin
        valid_s     = {ENTRIES{1'b0}};
        ready_s     = {ENTRIES{1'b0}};
        wake1_s     = {ENTRIES{1'b0}};
        wake2_s     = {ENTRIES{1'b0}};
        issue_mux_s = ISSUE_NONE;
        for (int i = 0; i < ENTRIES; i++) begin
            valid_s[i] = entry_r[i].valid;
            ready_s[i] = entry_r[i].valid && !entry_r[i].pend1 && !entry_r[i].pend2;
            wake1_s[i] = entry_r[i].valid && cdb_hit(entry_r[i].pend1, entry_r[i].tag1, cdbValid, cdbROB);
            wake2_s[i] = entry_r[i].valid && cdb_hit(entry_r[i].pend2, entry_r[i].tag2, cdbValid, cdbROB);
            issue_mux_s = issue_mux_s | (oldest_s[i] ? to_issue(entry_r[i]) : ISSUE_NONE);
        end
        rs_full_s  = &valid_s;
        dispatch_s = stationRequest && (RSstation == STATION_ID) && !rs_full_s && !flush;
        free_vec_s = ~valid_s;
        if (dispatch_s) begin
            alloc_s = free_vec_s & (~free_vec_s + {{(ENTRIES-1){1'b0}}, 1'b1});
        end else begin
            alloc_s = {ENTRIES{1'b0}};
        end
        issue_load_s = !issue_valid_r || fuReady;
        if (issue_load_s) begin
            issue_sel_s = oldest_s;
        end else begin
            issue_sel_s = {ENTRIES{1'b0}};
        end
        bypass1_s         = cdb_hit(busy1, rob1, cdbValid, cdbROB);
        bypass2_s         = cdb_hit(busy2, rob2, cdbValid, cdbROB);
        new_entry_s.valid = 1'b1;
        new_entry_s.aluc  = ALUControl;
        new_entry_s.op1   = bypass1_s ? cdbResult : operand1;
        new_entry_s.op2   = bypass2_s ? cdbResult : operand2;
        new_entry_s.pend1 = busy1 && !bypass1_s;
        new_entry_s.pend2 = busy2 && !bypass2_s;
        new_entry_s.tag1  = rob1;
        new_entry_s.tag2  = rob2;
        new_entry_s.dest  = destROB;
        new_entry_s.pc    = pc;
    end

    // Entry storage and the issue register; flush discards everything including the CDB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_r[i].valid <= 1'b0;
            end
            issue_valid_r <= 1'b0;
            issue_r       <= ISSUE_NONE;
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_r[i].valid <= 1'b0;
            end
            issue_valid_r <= 1'b0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (alloc_s[i]) begin
                    entry_r[i] <= new_entry_s;
                end else if (issue_sel_s[i]) begin
                    entry_r[i].valid <= 1'b0;
                end else begin
                    if (wake1_s[i]) begin
                        entry_r[i].op1   <= cdbResult;
                        entry_r[i].pend1 <= 1'b0;
                    end
                    if (wake2_s[i]) begin
                        entry_r[i].op2   <= cdbResult;
                        entry_r[i].pend2 <= 1'b0;
                    end
                end
            end
            if (issue_load_s) begin
                issue_valid_r <= |issue_sel_s;
                issue_r       <= issue_mux_s;
            end
        end
    end

    assign rsFull          = rs_full_s;
    assign issueValid      = issue_valid_r;
    assign issueALUControl = issue_r.aluc;
    assign issueOp1        = issue_r.op1;
    assign issueOp2        = issue_r.op2;
    assign issueROB        = issue_r.rob;
    assign issuePC         = issue_r.pc;

endmodule
